shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 123 ++++++++++++
 tb/tb_shift_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate sequencer that drives an external combinational SHIFT32.
// SRA and nonzero rotates take two passes; all other ops take one pass, then a one-cycle FIN.
module shift_seq #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [2:0]   OP,
  input  logic [W-1:0] D,
  input  logic [W-1:0] S,
  output logic [W-1:0] Y,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] SH_D,
  output logic [W-1:0] SH_S,
  output logic         SH_LnR,
  input  logic [W-1:0] SH_Y
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  localparam logic [W-1:0] WIDTH = W;
  localparam logic [W-1:0] ONES  = '1;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, FIN} state_e;

  state_e       state, nxt;
  logic [2:0]   op_q;
  logic [W-1:0] d_q, s_q, a_q, y_q;

  logic         rot, two_pass, take;
  logic [4:0]   n;
  logic [W-1:0] n_w, n_inv;

  assign rot      = (op_q == OP_ROL) || (op_q == OP_ROR);
  assign n        = s_q[4:0];
  assign n_w      = {{(W-5){1'b0}}, n};
  assign n_inv    = WIDTH - n_w;
  assign two_pass = (op_q == OP_SRA) || (rot && (n != 5'd0));
  // RST gates START so nothing is accepted while reset is held
  assign take     = START && !RST;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (take) nxt = PASS1;
      PASS1:   nxt = two_pass ? PASS2 : FIN;
      PASS2:   nxt = FIN;
      FIN:     nxt = take ? PASS1 : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Shifter operands: (data, amount, left) per op and pass
  always_comb begin
    SH_D   = '0;
    SH_S   = '0;
    SH_LnR = 1'b1;
    if (state == PASS1) begin
      SH_D = d_q;
      case (op_q)
        OP_SLL: begin SH_S = s_q; SH_LnR = 1'b1; end
        OP_SRL: begin SH_S = s_q; SH_LnR = 1'b0; end
        OP_SRA: begin SH_S = s_q; SH_LnR = 1'b0; end
        OP_ROL: begin SH_S = n_w; SH_LnR = 1'b1; end
        OP_ROR: begin SH_S = n_w; SH_LnR = (n == 5'd0); end
        default: begin SH_S = '0; SH_LnR = 1'b1; end
      endcase
    end else if (state == PASS2) begin
      case (op_q)
        OP_SRA: begin SH_D = ONES; SH_S = s_q;   SH_LnR = 1'b0; end
        OP_ROL: begin SH_D = d_q;  SH_S = n_inv; SH_LnR = 1'b0; end
        OP_ROR: begin SH_D = d_q;  SH_S = n_inv; SH_LnR = 1'b1; end
        default: begin SH_D = '0;  SH_S = '0;    SH_LnR = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      op_q  <= '0;
      d_q   <= '0;
      s_q   <= '0;
      a_q   <= '0;
      y_q   <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE, FIN: begin
          if (take) begin
            op_q <= OP;
            d_q  <= D;
            s_q  <= S;
          end
        end
        PASS1: begin
          a_q <= SH_Y;
          if (!two_pass)
            y_q <= (op_q == OP_SLL || op_q == OP_SRL) ? SH_Y : d_q;
        end
        PASS2: begin
          // SRA: second pass is the fill mask; its complement supplies the sign bits
          if (op_q == OP_SRA)
            y_q <= d_q[W-1] ? (a_q | ~SH_Y) : a_q;
          else
            y_q <= a_q | SH_Y;
        end
        default: ;
      endcase
    end
  end

  assign Y    = y_q;
  assign BUSY = (state == PASS1) || (state == PASS2);
  assign DONE = (state == FIN);

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed table, back-to-back/reset sequences, random ops.
// A behavioural SHIFT32 is attached; expected results come from a plain-arithmetic model.
module tb_shift_seq;

  logic        CLK = 1'b0;
  logic        RST, START;
  logic [2:0]  OP;
  logic [31:0] D, S, Y, SH_D, SH_S, SH_Y;
  logic        BUSY, DONE, SH_LnR;

  int npass = 0;
  int ntot  = 0;
  int excl_viol = 0;

  always #5 CLK = ~CLK;

  assign SH_Y = SH_LnR ? (SH_D << SH_S) : (SH_D >> SH_S);

  shift_seq #(.W(32)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .D(D), .S(S),
    .Y(Y), .BUSY(BUSY), .DONE(DONE),
    .SH_D(SH_D), .SH_S(SH_S), .SH_LnR(SH_LnR), .SH_Y(SH_Y)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d;
    logic [31:0] s;
    logic [31:0] y;
    int          lat;
  } vec_t;

  always @(negedge CLK) if (BUSY && DONE) excl_viol++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_y(input logic [2:0] op, input logic [31:0] d,
                                        input logic [31:0] s);
    int n;
    n = int'(s % 32);
    case (op)
      3'd0: return (s >= 32) ? 32'h0 : d << s[4:0];
      3'd1: return (s >= 32) ? 32'h0 : d >> s[4:0];
      3'd2: return (s >= 32) ? {32{d[31]}} : 32'($signed(d) >>> s[4:0]);
      3'd3: return (n == 0) ? d : ((d << n) | (d >> (32 - n)));
      3'd4: return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
      default: return d;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] s);
    if (op == 3'd2) return 3;
    if ((op == 3'd3 || op == 3'd4) && (s % 32) != 0) return 3;
    return 2;
  endfunction

  // Issue one request and count edges from the accepting edge's setup until DONE
  task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] d,
                       input logic [31:0] s, input logic [31:0] ey, input int elat);
    int lat;
    @(negedge CLK);
    START = 1'b1; OP = op; D = d; S = s;
    @(negedge CLK);
    START = 1'b0;
    lat = 1;
    while (!DONE && lat < 8) begin
      @(negedge CLK);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(elat));
    chk({nm, " y"}, Y, ey);
    @(negedge CLK);
    chk({nm, " done pulse"}, {31'b0, DONE}, 32'h0);
  endtask

  initial begin
    vec_t tbl[$];
    RST = 1'b1; START = 1'b0; OP = '0; D = '0; S = '0;

    tbl.push_back('{3'd0, 32'hA5A5A5A5, 32'd4,  32'h5A5A5A50, 2});
    tbl.push_back('{3'd1, 32'hA5A5A5A5, 32'd4,  32'h0A5A5A5A, 2});
    tbl.push_back('{3'd0, 32'hA5A5A5A5, 32'd32, 32'h00000000, 2});
    tbl.push_back('{3'd1, 32'hA5A5A5A5, 32'd32, 32'h00000000, 2});
    tbl.push_back('{3'd0, 32'h00000001, 32'd31, 32'h80000000, 2});
    tbl.push_back('{3'd2, 32'h80000000, 32'd4,  32'hF8000000, 3});
    tbl.push_back('{3'd2, 32'h80000000, 32'd40, 32'hFFFFFFFF, 3});
    tbl.push_back('{3'd2, 32'h7FFFFFFF, 32'd40, 32'h00000000, 3});
    tbl.push_back('{3'd3, 32'hA5A5A5A5, 32'd4,  32'h5A5A5A5A, 3});
    tbl.push_back('{3'd4, 32'h00000001, 32'd1,  32'h80000000, 3});
    tbl.push_back('{3'd3, 32'h12345678, 32'd32, 32'h12345678, 2});
    tbl.push_back('{3'd4, 32'h12345678, 32'h24, 32'h81234567, 3});
    tbl.push_back('{3'd7, 32'hDEADBEEF, 32'd5,  32'hDEADBEEF, 2});
    tbl.push_back('{3'd5, 32'h0000FFFF, 32'd3,  32'h0000FFFF, 2});

    #12;
    chk("rst y", Y, 32'h0);
    chk("rst busy_done", {30'b0, BUSY, DONE}, 32'h0);
    chk("rst sh_d", SH_D, 32'h0);
    chk("rst sh_s", SH_S, 32'h0);
    chk("rst sh_lnr", {31'b0, SH_LnR}, 32'h1);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].d, tbl[i].s, tbl[i].y, tbl[i].lat);

    // Rotate pass operands seen by the shifter
    @(negedge CLK);
    START = 1'b1; OP = 3'd3; D = 32'hA5A5A5A5; S = 32'd4;
    @(negedge CLK);
    START = 1'b0;
    chk("rol p1 sh_s", SH_S, 32'd4);
    chk("rol p1 lnr", {31'b0, SH_LnR}, 32'h1);
    @(negedge CLK);
    chk("rol p2 sh_s", SH_S, 32'd28);
    chk("rol p2 lnr", {31'b0, SH_LnR}, 32'h0);
    @(negedge CLK);
    chk("rol seq y", Y, 32'h5A5A5A5A);
    chk("fin sh_lnr", {31'b0, SH_LnR}, 32'h1);

    // START held through an SRA: ignored while busy, accepted in FIN
    @(negedge CLK);
    START = 1'b1; OP = 3'd2; D = 32'h80000000; S = 32'd4;
    @(negedge CLK);
    OP = 3'd0; D = 32'h00000001; S = 32'd3;
    chk("hold busy p1", {31'b0, BUSY}, 32'h1);
    @(negedge CLK);
    chk("hold busy p2", {31'b0, BUSY}, 32'h1);
    @(negedge CLK);
    chk("hold done1", {31'b0, DONE}, 32'h1);
    chk("hold y1", Y, 32'hF8000000);
    @(negedge CLK);
    START = 1'b0;
    chk("b2b busy", {30'b0, BUSY, DONE}, 32'h2);
    @(negedge CLK);
    chk("b2b done2", {31'b0, DONE}, 32'h1);
    chk("b2b y2", Y, 32'h00000008);

    // Reset in PASS2 aborts the SRA
    @(negedge CLK);
    START = 1'b1; OP = 3'd2; D = 32'h80000000; S = 32'd4;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    chk("abort in p2", {31'b0, BUSY}, 32'h1);
    #2 RST = 1'b1;
    #1;
    chk("async rst y", Y, 32'h0);
    chk("async rst flags", {30'b0, BUSY, DONE}, 32'h0);
    chk("async rst sh", {SH_D[15:0], SH_S[14:0], SH_LnR}, 32'h1);
    @(negedge CLK);
    RST = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge CLK);
        if (DONE) seen++;
      end
      chk("no done after abort", 32'(seen), 32'h0);
    end
    do_op("post rst sll", 3'd0, 32'h0000000F, 32'd8, 32'h00000F00, 2);

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] d, s;
      op = 3'($urandom_range(0, 7));
      d  = $urandom;
      s  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      do_op($sformatf("rnd%0d op%0d", i, op), op, d, s, ref_y(op, d, s), ref_lat(op, s));
    end

    chk("busy/done exclusive", 32'(excl_viol), 32'h0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
